// File: rtl/pipelined_alu_core.sv
// Four-stage (IF, ID, EX, WB) RV32I/RV64I ALU-only pipeline with an internal
// instruction memory and EX/WB-to-ID operand forwarding.
module pipelined_alu_core #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int IMEM_AW    = 6,
    parameter int RETIRE_W   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic                imem_we,
    input  logic [IMEM_AW-1:0]  imem_addr,
    input  logic [31:0]         imem_wdata,
    input  logic [4:0]          dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    output logic [XLEN-1:0]     pc,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                zero,
    output logic [RETIRE_W-1:0] retired
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [11-SHW:0] SRA_HI = {2'b01, {(10-SHW){1'b0}}};

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } aluOp_t;

    logic [31:0]         r_imem [IMEM_DEPTH];
    logic [XLEN-1:0]     r_regs [32];
    logic [XLEN-1:0]     r_pc;
    logic                r_idValid;
    logic [31:0]         r_idInstr;
    logic                r_exValid;
    aluOp_t              r_exOp;
    logic [4:0]          r_exRd;
    logic [XLEN-1:0]     r_exA;
    logic [XLEN-1:0]     r_exB;
    logic                r_wbValid;
    logic [4:0]          r_wbRd;
    logic [XLEN-1:0]     r_wbData;
    logic                r_zero;
    logic [RETIRE_W-1:0] r_retired;

    logic [IMEM_AW-1:0]  w_fetchIdx;
    logic [IMEM_AW-1:0]  w_fetchNext;
    logic [XLEN-1:0]     w_pcNext;
    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [6:0]          w_funct7;
    logic [4:0]          w_rs1;
    logic [4:0]          w_rs2;
    logic [4:0]          w_rd;
    logic [11-SHW:0]     w_shiftHi;
    logic [XLEN-1:0]     w_imm;
    logic                w_decOk;
    aluOp_t              w_decOp;
    logic                w_useImm;
    logic [XLEN-1:0]     w_opA;
    logic [XLEN-1:0]     w_rs2Val;
    logic [XLEN-1:0]     w_opB;
    logic [SHW-1:0]      w_shamt;
    logic [XLEN-1:0]     w_exResult;

    // The word index wraps on its own, so pc returns to 0 after the last word.
    assign w_fetchIdx  = r_pc[IMEM_AW+1:2];
    assign w_fetchNext = w_fetchIdx + 1'b1;
    assign w_pcNext    = {{(XLEN-IMEM_AW-2){1'b0}}, w_fetchNext, 2'b00};

    assign w_opcode  = r_idInstr[6:0];
    assign w_rd      = r_idInstr[11:7];
    assign w_funct3  = r_idInstr[14:12];
    assign w_rs1     = r_idInstr[19:15];
    assign w_rs2     = r_idInstr[24:20];
    assign w_funct7  = r_idInstr[31:25];
    assign w_shiftHi = r_idInstr[31:20+SHW];
    assign w_imm     = {{(XLEN-12){r_idInstr[31]}}, r_idInstr[31:20]};

    always_comb begin
        w_decOk  = 1'b0;
        w_decOp  = OP_ADD;
        w_useImm = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                if (w_funct7 == 7'b0000000) begin
                    w_decOk = 1'b1;
                    case (w_funct3)
                        3'b000:  w_decOp = OP_ADD;
                        3'b001:  w_decOp = OP_SLL;
                        3'b010:  w_decOp = OP_SLT;
                        3'b011:  w_decOp = OP_SLTU;
                        3'b100:  w_decOp = OP_XOR;
                        3'b101:  w_decOp = OP_SRL;
                        3'b110:  w_decOp = OP_OR;
                        3'b111:  w_decOp = OP_AND;
                        default: w_decOk = 1'b0;
                    endcase
                end else if (w_funct7 == 7'b0100000) begin
                    if (w_funct3 == 3'b000) begin
                        w_decOk = 1'b1;
                        w_decOp = OP_SUB;
                    end else if (w_funct3 == 3'b101) begin
                        w_decOk = 1'b1;
                        w_decOp = OP_SRA;
                    end
                end
            end
            7'b0010011: begin
                w_useImm = 1'b1;
                w_decOk  = 1'b1;
                case (w_funct3)
                    3'b000:  w_decOp = OP_ADD;
                    3'b010:  w_decOp = OP_SLT;
                    3'b011:  w_decOp = OP_SLTU;
                    3'b100:  w_decOp = OP_XOR;
                    3'b110:  w_decOp = OP_OR;
                    3'b111:  w_decOp = OP_AND;
                    3'b001: begin
                        w_decOp = OP_SLL;
                        w_decOk = (w_shiftHi == '0);
                    end
                    3'b101: begin
                        w_decOp = (w_shiftHi == SRA_HI) ? OP_SRA : OP_SRL;
                        w_decOk = (w_shiftHi == '0) || (w_shiftHi == SRA_HI);
                    end
                    default: w_decOk = 1'b0;
                endcase
            end
            default: w_decOk = 1'b0;
        endcase
    end

    // Youngest producer wins: EX result beats WB result beats the register file.
    always_comb begin
        if (w_rs1 == 5'd0)
            w_opA = '0;
        else if (r_exValid && (r_exRd == w_rs1))
            w_opA = w_exResult;
        else if (r_wbValid && (r_wbRd == w_rs1))
            w_opA = r_wbData;
        else
            w_opA = r_regs[w_rs1];
    end

    always_comb begin
        if (w_rs2 == 5'd0)
            w_rs2Val = '0;
        else if (r_exValid && (r_exRd == w_rs2))
            w_rs2Val = w_exResult;
        else if (r_wbValid && (r_wbRd == w_rs2))
            w_rs2Val = r_wbData;
        else
            w_rs2Val = r_regs[w_rs2];
    end

    assign w_opB   = w_useImm ? w_imm : w_rs2Val;
    assign w_shamt = r_exB[SHW-1:0];

    always_comb begin
        w_exResult = '0;
        case (r_exOp)
            OP_ADD:  w_exResult = r_exA + r_exB;
            OP_SUB:  w_exResult = r_exA - r_exB;
            OP_SLL:  w_exResult = r_exA << w_shamt;
            OP_SLT:  w_exResult = {{(XLEN-1){1'b0}}, ($signed(r_exA) < $signed(r_exB))};
            OP_SLTU: w_exResult = {{(XLEN-1){1'b0}}, (r_exA < r_exB)};
            OP_XOR:  w_exResult = r_exA ^ r_exB;
            OP_SRL:  w_exResult = r_exA >> w_shamt;
            OP_SRA:  w_exResult = $signed(r_exA) >>> w_shamt;
            OP_OR:   w_exResult = r_exA | r_exB;
            OP_AND:  w_exResult = r_exA & r_exB;
            default: w_exResult = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc      <= '0;
            r_idValid <= 1'b0;
            r_exValid <= 1'b0;
            r_wbValid <= 1'b0;
            r_zero    <= 1'b0;
            r_retired <= '0;
            for (int i = 0; i < 32; i++)
                r_regs[i] <= '0;
        end else if (run) begin
            r_pc      <= w_pcNext;
            r_idValid <= 1'b1;
            r_idInstr <= r_imem[w_fetchIdx];
            r_exValid <= r_idValid && w_decOk;
            r_exOp    <= w_decOp;
            r_exRd    <= w_rd;
            r_exA     <= w_opA;
            r_exB     <= w_opB;
            r_wbValid <= r_exValid;
            r_wbRd    <= r_exRd;
            r_wbData  <= w_exResult;
            if (r_wbValid) begin
                if (r_wbRd != 5'd0)
                    r_regs[r_wbRd] <= r_wbData;
                r_zero <= (r_wbData == '0);
                if (r_retired != '1)
                    r_retired <= r_retired + 1'b1;
            end
        end
    end

    // Instruction memory is never reset; loads are only accepted while halted.
    always_ff @(posedge clock) begin
        if (!reset && !run && imem_we)
            r_imem[imem_addr] <= imem_wdata;
    end

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];
    assign pc       = r_pc;
    assign wb_valid = r_wbValid;
    assign wb_rd    = r_wbRd;
    assign wb_data  = r_wbData;
    assign zero     = r_zero;
    assign retired  = r_retired;

endmodule
